// File: rtl/uart_tx_fifo.sv
// Serial transmitter with an input FIFO. Frame format (data width, parity, stop bits) and
// baud divider are set by parameters. Bits go out LSB-first on a registered line.
module uart_tx_fifo #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_MODE  = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4,
   localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 din_valid,
   input  logic [DATA_BITS-1:0] din_byte,
   output logic                 uart_ready,
   output logic                 ser_out,
   output logic                 tx_busy,
   output logic [LVL_W-1:0]     fifo_level,
   output logic                 tx_ovf
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] word_q, word_d;
   logic                 ser_q, ser_d;
   logic                 ovf_q;
   logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

   logic                 full, empty, push, pop, bit_end, par_bit;
   logic [DATA_BITS-1:0] head;

   assign fifo_level = LVL_W'(wr_ptr_q - rd_ptr_q);
   assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
   assign empty      = (fifo_level == '0);
   // Readiness comes from the pre-pop level, so a full FIFO never takes a push.
   assign uart_ready = ~full;
   assign push       = din_valid & ~full;
   assign head       = mem[rd_ptr_q[PTR_W-1:0]];
   assign bit_end    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
   assign par_bit    = (PARITY_MODE == 1) ? ^word_q : ~^word_q;
   assign ser_out    = ser_q;
   assign tx_ovf     = ovf_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q[PTR_W-1:0]] <= din_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         bcnt_q   <= '0;
         shift_q  <= '0;
         word_q   <= '0;
         ser_q    <= 1'b1;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bcnt_q   <= bcnt_d;
         shift_q  <= shift_d;
         word_q   <= word_d;
         ser_q    <= ser_d;
         ovf_q    <= din_valid & full;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      word_d  = word_q;
      pop     = 1'b0;
      if (state_q != StIdle) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      case (state_q)
         StIdle:   pop = ~empty;
         StStart:  if (bit_end) begin
            state_d = StData;
            bcnt_d  = '0;
         end
         StData:   if (bit_end) begin
            shift_d = shift_q >> 1;
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == BIT_W'(DATA_BITS - 1)) begin
               bcnt_d  = '0;
               state_d = (PARITY_MODE != 0) ? StParity : StStop;
            end
         end
         StParity: if (bit_end) begin
            state_d = StStop;
            bcnt_d  = '0;
         end
         StStop:   if (bit_end) begin
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == BIT_W'(STOP_BITS - 1)) begin
               bcnt_d  = '0;
               state_d = StIdle;
               pop     = ~empty;
            end
         end
         default:  state_d = StIdle;
      endcase
      // A pop always launches a new frame, from idle or straight out of the last stop bit.
      if (pop) begin
         state_d = StStart;
         cnt_d   = '0;
         shift_d = head;
         word_d  = head;
      end
   end

   // Line level is derived from the next state so it changes on the same edge.
   always_comb begin
      ser_d = 1'b1;
      case (state_d)
         StStart:  ser_d = 1'b0;
         StData:   ser_d = shift_d[0];
         StParity: ser_d = par_bit;
         default:  ser_d = 1'b1;
      endcase
   end

   assign tx_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model feeding a scoreboard, line monitors
// that decode ser_out independently, plus a second narrow 5-bit odd-parity two-stop instance.
module tb_uart_tx_fifo;

   localparam int FD    = 4;
   localparam int CPB   = 4;
   localparam int FRAME = 11 * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       din_valid = 1'b0;
   logic [7:0] din_byte = '0;
   logic       uart_ready, ser_out, tx_busy, tx_ovf;
   logic [2:0] fifo_level;

   logic       din2_valid = 1'b0;
   logic [4:0] din2_byte = '0;
   logic       ready2, ser2, busy2, ovf2;
   logic [1:0] level2;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_byte(din_byte),
      .uart_ready(uart_ready), .ser_out(ser_out), .tx_busy(tx_busy),
      .fifo_level(fifo_level), .tx_ovf(tx_ovf)
   );

   uart_tx_fifo #(
      .DATA_BITS(5), .CLKS_PER_BIT(1), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(2)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .din_valid(din2_valid), .din_byte(din2_byte),
      .uart_ready(ready2), .ser_out(ser2), .tx_busy(busy2),
      .fifo_level(level2), .tx_ovf(ovf2)
   );

   typedef struct { logic [7:0] w; int start; } exp_t;
   typedef struct { logic [8:0] bits; int start; } exp2_t;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Reference model: words waiting, cycles left in the frame on the line.
   logic [7:0] m_q[$];
   exp_t       exp_q[$];
   exp2_t      q2[$];
   int         tx_rem = 0;
   bit         m_ovf = 1'b0;
   int         m_frames = 0;
   int         seen = 0;
   int         seen2 = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   initial begin
      bit   full, pop;
      exp_t e;
      forever begin
         @(posedge clk);
         if (rst_n) begin
            full  = (m_q.size() >= FD);
            pop   = (m_q.size() > 0) && (tx_rem <= 1);
            m_ovf = din_valid && full;
            if (din_valid && !full) m_q.push_back(din_byte);
            if (pop) begin
               e.w     = m_q.pop_front();
               e.start = cyc;
               exp_q.push_back(e);
               m_frames++;
               tx_rem = FRAME;
            end else if (tx_rem > 0) begin
               tx_rem--;
            end
         end
         cyc++;
      end
   end

   // Per-cycle status against the model.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("fifo_level", fifo_level, m_q.size());
         chk("uart_ready", uart_ready, m_q.size() < FD);
         chk("tx_busy", tx_busy, tx_rem > 0);
         chk("tx_ovf", tx_ovf, m_ovf);
      end
   end

   // Main line monitor: decode each frame, then pop and compare.
   initial begin
      int          st;
      logic [10:0] bits, xb;
      bit          ab, hb;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst_n && ser_out === 1'b0) begin
            st = cyc - 1;
            ab = 1'b0;
            hb = 1'b0;
            for (int k = 0; k < 11 && !ab; k++) begin
               for (int j = 0; j < CPB && !ab; j++) begin
                  if (k != 0 || j != 0) @(negedge clk);
                  if (!rst_n) ab = 1'b1;
                  else if (j == 0) bits[k] = ser_out;
                  else if (ser_out !== bits[k]) hb = 1'b1;
               end
            end
            if (!ab) begin
               seen++;
               chk("frame_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e  = exp_q.pop_front();
                  xb = {1'b1, ^e.w, e.w, 1'b0};
                  chk("frame_bits", bits, xb);
                  chk("frame_start", st, e.start);
                  chk("bit_hold", hb, 0);
               end
            end
         end
      end
   end

   // Narrow-instance monitor: one clock per bit, 9-bit frames.
   initial begin
      int         st;
      logic [8:0] b;
      bit         ab, hb;
      exp2_t      x;
      forever begin
         @(negedge clk);
         if (rst_n && ser2 === 1'b0) begin
            st = cyc - 1;
            ab = 1'b0;
            hb = 1'b0;
            for (int k = 0; k < 9 && !ab; k++) begin
               if (k > 0) @(negedge clk);
               if (!rst_n) ab = 1'b1;
               else begin
                  b[k] = ser2;
                  if (busy2 !== 1'b1) hb = 1'b1;
               end
            end
            if (!ab) begin
               seen2++;
               chk("u2_frame_expected", q2.size() > 0, 1);
               if (q2.size() > 0) begin
                  x = q2.pop_front();
                  chk("u2_frame_bits", b, x.bits);
                  chk("u2_frame_start", st, x.start);
                  chk("u2_busy", hb, 0);
               end
            end
         end
      end
   end

   task automatic clear_model();
      if (tx_rem > 0) m_frames--;
      m_q.delete();
      exp_q.delete();
      tx_rem = 0;
      m_ovf  = 1'b0;
   endtask

   task automatic push1(input logic [7:0] w);
      @(negedge clk);
      din_valid = 1'b1;
      din_byte  = w;
      @(negedge clk);
      din_valid = 1'b0;
      din_byte  = ~w;
   endtask

   task automatic push_burst(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         din_valid = 1'b1;
         din_byte  = 8'($urandom);
      end
      @(negedge clk);
      din_valid = 1'b0;
      din_byte  = 8'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((tx_rem != 0 || m_q.size() != 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", n < 3000, 1);
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_rem(input int r);
      int n = 0;
      while (tx_rem != r && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_rem_timeout", n < 200, 1);
   endtask

   task automatic push2(input logic [4:0] w);
      exp2_t x;
      @(negedge clk);
      x.bits  = {2'b11, ~^w, w, 1'b0};
      x.start = cyc + 1;
      q2.push_back(x);
      din2_valid = 1'b1;
      din2_byte  = w;
      @(negedge clk);
      din2_valid = 1'b0;
      din2_byte  = ~w;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ser_out", ser_out, 1);
      chk("rst_tx_busy", tx_busy, 0);
      chk("rst_uart_ready", uart_ready, 1);
      chk("rst_fifo_level", fifo_level, 0);
      chk("rst_tx_ovf", tx_ovf, 0);
      chk("rst_ser2", ser2, 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      push1(8'hA5);
      wait_idle();
      push1(8'h07);
      wait_idle();
      push1(8'h00);
      wait_idle();

      // Six back-to-back pushes: first pops at once, sixth hits a full FIFO.
      push_burst(6);
      wait_idle();

      // Push lands on the same edge as the stop-bit-end pop with two words queued.
      push_burst(3);
      wait_rem(1);
      din_valid = 1'b1;
      din_byte  = 8'($urandom);
      @(negedge clk);
      din_valid = 1'b0;
      chk("level_push_pop", fifo_level, 2);
      wait_idle();

      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         din_valid = ($urandom_range(0, 9) < 2);
         din_byte  = 8'($urandom);
      end
      @(negedge clk);
      din_valid = 1'b0;
      wait_idle();

      // Reset in the middle of data bit 1 of the first of three queued frames.
      push_burst(3);
      wait_rem(FRAME - 9);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      clear_model();
      #1;
      chk("midrst_ser_out", ser_out, 1);
      chk("midrst_fifo_level", fifo_level, 0);
      chk("midrst_uart_ready", uart_ready, 1);
      chk("midrst_tx_busy", tx_busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (80) @(negedge clk);
      push1(8'h3C);
      wait_idle();

      push2(5'h1F);
      for (int i = 0; i < 6; i++) push2(5'($urandom));
      repeat (4) @(negedge clk);

      chk("frames_left", exp_q.size(), 0);
      chk("frames_seen", seen, m_frames);
      chk("u2_frames_left", q2.size(), 0);
      chk("u2_frames_seen", seen2, 7);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
